// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: computes a - b - b_in as a + ~b + ~b_in,
// CHUNK bits per cycle with carry lookahead inside each chunk. WIDTH must be a multiple of CHUNK.
module serial_subtractor #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  input  logic             io_in_b_in,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_d,
  output logic             io_out_b_out,
  output logic             io_out_zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] nb_r;
  logic [WIDTH-1:0] d_r;
  logic             carry;
  logic             b_out_r;
  logic [CW-1:0]    k;

  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] nb_k;
  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] sum;
  logic             cy;
  logic             c_out;

  // Chunk select and lookahead add; cy is a blocking scratch variable that
  // walks the carry chain bit by bit within one evaluation.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    a_k  = '0;
    nb_k = '0;
    for (int j = 0; j < NCHUNK; j++) begin
      if (k == CW'(j)) begin
        a_k  = a_r[j*CHUNK +: CHUNK];
        nb_k = nb_r[j*CHUNK +: CHUNK];
      end
    end
    p   = a_k | nb_k;
    g   = a_k & nb_k;
    sum = '0;
    cy  = carry;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a_k[i] ^ nb_k[i] ^ cy;
      cy     = (cy & p[i]) | g[i];
    end
    c_out = cy;
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all updates take effect together at the edge.
    if (reset) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a_r         <= '0;
      nb_r        <= '0;
      d_r         <= '0;
      carry       <= 1'b0;
      b_out_r     <= 1'b0;
      k           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid) begin
            a_r        <= io_in_a;
            nb_r       <= ~io_in_b;
            carry      <= ~io_in_b_in;
            k          <= '0;
            state      <= BUSY;
            in_ready_r <= 1'b0;
          end
        end
        BUSY: begin
          for (int j = 0; j < NCHUNK; j++) begin
            if (k == CW'(j)) d_r[j*CHUNK +: CHUNK] <= sum;
          end
          carry <= c_out;
          // Counter holds at the last chunk rather than wrapping.
          if (k == K_LAST) begin
            b_out_r     <= ~c_out;
            state       <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (io_out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign io_in_ready  = in_ready_r;
  assign io_out_valid = out_valid_r;
  assign io_out_d     = d_r;
  assign io_out_b_out = b_out_r;
  assign io_out_zero  = (d_r == '0);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=12, CHUNK=3: reset values, latency,
// borrow corner cases, backpressure, mid-operation reset and back-to-back capture.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [11:0] io_in_a;
  logic [11:0] io_in_b;
  logic        io_in_b_in;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [11:0] io_out_d;
  logic        io_out_b_out;
  logic        io_out_zero;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(12), .CHUNK(3)) dut (
    .clock       (clk),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_in_a     (io_in_a),
    .io_in_b     (io_in_b),
    .io_in_b_in  (io_in_b_in),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_d    (io_out_d),
    .io_out_b_out(io_out_b_out),
    .io_out_zero (io_out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: 13-bit difference, top bit is the borrow.
  function automatic logic [12:0] model(input logic [11:0] a, input logic [11:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - 13'(bin);
  endfunction

  task automatic wait_ready(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (io_in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({tag, " ready_timeout"}, 32'd0, 32'd1);
  endtask

  // One full transaction; result held for 'hold' extra cycles with io_out_ready low.
  task automatic run_op(input string tag, input logic [11:0] a, input logic [11:0] b,
                        input logic bin, input logic [11:0] exp_d, input logic exp_bo,
                        input logic exp_z, input int hold);
    bit ok;
    int lat;
    @(negedge clk);
    wait_ready(tag, ok);
    if (!ok) return;
    io_in_a     = a;
    io_in_b     = b;
    io_in_b_in  = bin;
    io_in_valid = 1'b1;
    @(negedge clk);
    io_in_valid = 1'b0;
    io_in_a     = a ^ 12'hA5A;
    io_in_b     = b ^ 12'h3C3;
    io_in_b_in  = ~bin;
    check({tag, " busy_ready"}, 32'(io_in_ready), 32'd0);
    lat = 1;
    while (io_out_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd5);
    if (io_out_valid !== 1'b1) return;
    check({tag, " d"}, 32'(io_out_d), 32'(exp_d));
    check({tag, " b_out"}, 32'(io_out_b_out), 32'(exp_bo));
    check({tag, " zero"}, 32'(io_out_zero), 32'(exp_z));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold_d"}, 32'(io_out_d), 32'(exp_d));
      check({tag, " hold_b_out"}, 32'(io_out_b_out), 32'(exp_bo));
      check({tag, " hold_zero"}, 32'(io_out_zero), 32'(exp_z));
      check({tag, " hold_valid"}, 32'(io_out_valid), 32'd1);
      check({tag, " hold_in_ready"}, 32'(io_in_ready), 32'd0);
    end
    io_out_ready = 1'b1;
    @(negedge clk);
    io_out_ready = 1'b0;
    check({tag, " post_valid"}, 32'(io_out_valid), 32'd0);
    check({tag, " post_in_ready"}, 32'(io_in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    bit          seen_valid;
    logic [12:0] exp_q[$];
    logic [12:0] e;
    int          caps;
    int          res;
    int          last_cap;

    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_a      = '0;
    io_in_b      = '0;
    io_in_b_in   = 1'b0;
    io_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst in_ready", 32'(io_in_ready), 32'd1);
    check("rst out_valid", 32'(io_out_valid), 32'd0);
    check("rst d", 32'(io_out_d), 32'd0);
    check("rst b_out", 32'(io_out_b_out), 32'd0);

    run_op("sub5_3", 12'h005, 12'h003, 1'b0, 12'h002, 1'b0, 1'b0, 0);
    run_op("sub0_1", 12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0, 0);
    run_op("eq_bin0", 12'h7AB, 12'h7AB, 1'b0, 12'h000, 1'b0, 1'b1, 0);
    run_op("eq_bin1", 12'h7AB, 12'h7AB, 1'b1, 12'hFFF, 1'b1, 1'b0, 0);
    run_op("zero_bin1", 12'h000, 12'h000, 1'b1, 12'hFFF, 1'b1, 1'b0, 0);
    run_op("max_min", 12'hFFF, 12'h000, 1'b0, 12'hFFF, 1'b0, 1'b0, 0);
    run_op("backpressure", 12'h456, 12'h123, 1'b1, 12'h332, 1'b0, 1'b0, 6);

    // Reset on the second BUSY cycle discards the operation.
    @(negedge clk);
    wait_ready("rst_busy", ok);
    io_in_a     = 12'h123;
    io_in_b     = 12'h456;
    io_in_b_in  = 1'b0;
    io_in_valid = 1'b1;
    @(negedge clk);
    io_in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy in_ready", 32'(io_in_ready), 32'd1);
    check("rst_busy out_valid", 32'(io_out_valid), 32'd0);
    check("rst_busy d", 32'(io_out_d), 32'd0);
    check("rst_busy b_out", 32'(io_out_b_out), 32'd0);
    seen_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (io_out_valid !== 1'b0) seen_valid = 1'b1;
    end
    check("rst_busy no_result", 32'(seen_valid), 32'd0);
    run_op("after_rst", 12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b0, 0);

    // io_in_valid during reset must not be captured.
    @(negedge clk);
    io_in_a     = 12'h111;
    io_in_b     = 12'h222;
    io_in_valid = 1'b1;
    reset       = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    io_in_valid = 1'b0;
    check("rst_valid in_ready", 32'(io_in_ready), 32'd1);
    seen_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (io_out_valid !== 1'b0) seen_valid = 1'b1;
    end
    check("rst_valid no_result", 32'(seen_valid), 32'd0);

    // Back-to-back: valid held high, operands change every cycle.
    caps         = 0;
    res          = 0;
    last_cap     = -100;
    io_out_ready = 1'b1;
    io_in_valid  = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (cyc == 40) io_in_valid = 1'b0;
      io_in_a    = 12'(cyc * 12'h1F3 + 7);
      io_in_b    = 12'(cyc * 12'h2C5);
      io_in_b_in = cyc[0];
      if (io_out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("b2b spurious_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("b2b d", 32'(io_out_d), 32'(e[11:0]));
          check("b2b b_out", 32'(io_out_b_out), 32'(e[12]));
          check("b2b zero", 32'(io_out_zero), 32'(e[11:0] == 12'h000));
        end
        res++;
      end
      if (io_in_ready === 1'b1 && io_in_valid) begin
        exp_q.push_back(model(io_in_a, io_in_b, io_in_b_in));
        if (caps > 0) check("b2b spacing", 32'(cyc - last_cap), 32'd6);
        last_cap = cyc;
        caps++;
      end
      @(negedge clk);
    end
    io_out_ready = 1'b0;
    check("b2b captures", 32'(caps), 32'd7);
    check("b2b results", 32'(res), 32'(caps));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
